// File: rtl/arc4_pkg.sv
// Shared constants, FSM state types and the printable-byte test for the
// double_crack ARC4 key-search engine.
package arc4_pkg;

  localparam int KEY_W  = 24;
  localparam int KEYLEN = 3;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_SEARCH,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    C_IDLE,
    C_INIT,
    C_KSA_RD,
    C_KSA_SW,
    C_PR_RD,
    C_PR_SW,
    C_PR_OUT,
    C_FAIL,
    C_PASS
  } core_state_e;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/crack_core.sv
// One ARC4 key-trial engine: S-box init, KSA, then PRGA-decrypt with early abort
// on the first non-printable byte. Walks KEY_START, KEY_START+KEY_STEP, ...
module crack_core
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'd0,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             advance,
  input  logic [7:0]       len,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_data,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [KEY_W-1:0] key
);

  localparam logic [KEY_W-1:0] KEY_LAST = KEY_START + KEY_STEP * ((~KEY_START) / KEY_STEP);

  core_state_e      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, t_q, t_d, k_q, k_d;
  logic [1:0]       m_q, m_d;

  logic [7:0] s_mem [256];
  logic       wa_en, wb_en;
  logic [7:0] wa_addr, wa_data, wb_addr, wb_data;
  logic [7:0] i_inc, s_i, s_j, s_in, s_t, kb, pt;

  assign i_inc = i_q + 8'd1;
  assign s_i   = s_mem[i_q];
  assign s_j   = s_mem[j_q];
  assign s_in  = s_mem[i_inc];
  assign s_t   = s_mem[t_q];

  always_comb begin
    case (m_q)
      2'd0:    kb = key_q[23:16];
      2'd1:    kb = key_q[15:8];
      default: kb = key_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    t_d     = t_q;
    k_d     = k_q;
    m_d     = m_q;
    wa_en   = 1'b0;
    wa_addr = i_q;
    wa_data = s_j;
    wb_en   = 1'b0;
    wb_addr = j_q;
    wb_data = si_q;
    pt      = s_t ^ ct_data;
    case (state_q)
      C_INIT: begin
        wa_en   = 1'b1;
        wa_data = i_q;
        i_d     = i_inc;
        if (i_q == 8'hFF) begin
          state_d = C_KSA_RD;
          j_d     = 8'd0;
          m_d     = 2'd0;
        end
      end
      C_KSA_RD: begin
        j_d     = j_q + s_i + kb;
        si_d    = s_i;
        state_d = C_KSA_SW;
      end
      C_KSA_SW: begin
        // If i==j both ports write the same value, so port order is irrelevant.
        wa_en = 1'b1;
        wb_en = 1'b1;
        i_d   = i_inc;
        m_d   = (m_q == 2'(KEYLEN - 1)) ? 2'd0 : m_q + 2'd1;
        if (i_q == 8'hFF) begin
          state_d = C_PR_RD;
          j_d     = 8'd0;
          k_d     = 8'd1;
        end else begin
          state_d = C_KSA_RD;
        end
      end
      C_PR_RD: begin
        i_d     = i_inc;
        si_d    = s_in;
        j_d     = j_q + s_in;
        state_d = C_PR_SW;
      end
      C_PR_SW: begin
        wa_en   = 1'b1;
        wb_en   = 1'b1;
        t_d     = si_q + s_j;
        state_d = C_PR_OUT;
      end
      C_PR_OUT: begin
        if (!is_print(pt)) begin
          state_d = C_FAIL;
        end else if (k_q == len) begin
          state_d = C_PASS;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = C_PR_RD;
        end
      end
      default: ;
    endcase
    // An empty message is trivially printable, so skip the schedule entirely.
    if (start) begin
      key_d   = KEY_START;
      i_d     = 8'd0;
      state_d = (len == 8'd0) ? C_PASS : C_INIT;
    end else if (advance && state_q == C_FAIL && !exhausted) begin
      key_d   = key_q + KEY_STEP;
      i_d     = 8'd0;
      state_d = (len == 8'd0) ? C_PASS : C_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= C_IDLE;
      key_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      t_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      t_q     <= t_d;
      k_q     <= k_d;
      m_q     <= m_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa_en) s_mem[wa_addr] <= wa_data;
    if (wb_en) s_mem[wb_addr] <= wb_data;
  end

  assign ct_addr   = k_q;
  assign busy      = !(state_q == C_IDLE || state_q == C_FAIL || state_q == C_PASS);
  assign found     = (state_q == C_PASS);
  assign exhausted = (state_q == C_FAIL) && (key_q == KEY_LAST);
  assign key       = key_q;

endmodule

// File: rtl/double_crack.sv
// Top of the ARC4 key search: copies the length-prefixed ciphertext into a local
// buffer, runs even/odd crack cores in lock-step rounds and latches the winner.
module double_crack
  import arc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic [7:0]       ct_addr,
  input  logic [7:0]       ct_rddata
);

  // Handshake: a request is accepted on a rising edge where en=1 and rdy=1;
  // en is ignored whenever rdy=0, and rdy stays low until the result is latched.
  state_e           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [7:0]       len_q, len_d, addr_q, addr_d;
  logic             start_pend_q, start_pend_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             kv_q, kv_d;

  logic [7:0]       ct_buf [256];
  logic             buf_we;
  logic [7:0]       buf_waddr;

  logic             core_start, core_adv;
  logic             busy0, busy1, found0, found1, exh0, exh1;
  logic [KEY_W-1:0] key0, key1;
  logic [7:0]       rd_addr0, rd_addr1;

  assign buf_waddr = cnt_q[7:0] - 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    addr_d       = addr_q;
    start_pend_d = 1'b0;
    key_d        = key_q;
    kv_d         = kv_q;
    buf_we       = 1'b0;
    core_start   = 1'b0;
    core_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_COPY;
          cnt_d   = 9'd0;
          addr_d  = 8'd0;
          kv_d    = 1'b0;
        end
      end
      ST_COPY: begin
        // Read data trails the address by one cycle, so byte n lands at cnt=n+1.
        cnt_d  = cnt_q + 9'd1;
        addr_d = addr_q + 8'd1;
        buf_we = (cnt_q != 9'd0);
        if (cnt_q == 9'd1) len_d = ct_rddata;
        if ((cnt_q == 9'd1 && ct_rddata == 8'd0) ||
            (cnt_q >= 9'd2 && cnt_q == {1'b0, len_q} + 9'd1)) begin
          state_d      = ST_SEARCH;
          addr_d       = 8'd0;
          start_pend_d = 1'b1;
        end
      end
      ST_SEARCH: begin
        if (start_pend_q) begin
          core_start = 1'b1;
        end else if (found0 || found1) begin
          state_d = ST_DONE;
          kv_d    = 1'b1;
          key_d   = found0 ? key0 : key1;
        end else if (!busy0 && !busy1) begin
          if (exh0 && exh1) begin
            state_d = ST_DONE;
            kv_d    = 1'b0;
            key_d   = '0;
          end else begin
            core_adv = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      start_pend_q <= 1'b0;
      key_q        <= '0;
      kv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      start_pend_q <= start_pend_d;
      key_q        <= key_d;
      kv_q         <= kv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) ct_buf[buf_waddr] <= ct_rddata;
  end

  crack_core #(.KEY_START(24'd0), .KEY_STEP(24'd2)) u_core0 (
    .clk(clk), .rst_n(rst_n), .start(core_start), .advance(core_adv), .len(len_q),
    .ct_addr(rd_addr0), .ct_data(ct_buf[rd_addr0]),
    .busy(busy0), .found(found0), .exhausted(exh0), .key(key0)
  );

  crack_core #(.KEY_START(24'd1), .KEY_STEP(24'd2)) u_core1 (
    .clk(clk), .rst_n(rst_n), .start(core_start), .advance(core_adv), .len(len_q),
    .ct_addr(rd_addr1), .ct_data(ct_buf[rd_addr1]),
    .busy(busy1), .found(found1), .exhausted(exh1), .key(key1)
  );

  assign rdy       = (state_q == ST_IDLE);
  assign key       = key_q;
  assign key_valid = kv_q;
  assign ct_addr   = addr_q;

endmodule

// File: tb/tb_double_crack.sv
// Directed bench for double_crack: table of ciphertexts with a reference ARC4
// model giving the expected first printable key, plus reset/en corner sequences.
module tb_double_crack;

  localparam int BUDGET = 30000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_q;

  logic [7:0]  ct_mem [256];
  logic [7:0]  ks_arr [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] enc_key;
    int          len;
    logic [63:0] msg;
    logic [23:0] exp_key;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) ct_q <= ct_mem[ct_addr];

  double_crack dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_q)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // Textbook byte-at-a-time RC4 keystream for a 3-byte key.
  function automatic void arc4_ks(input logic [23:0] k, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int i, j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = x[7:0];
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + int'(s[x]) + int'(kb[x % 3])) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int x = 0; x < n; x++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks_arr[x] = s[(int'(s[i]) + int'(s[j])) % 256];
    end
  endfunction

  function automatic logic [23:0] first_pass(input int n);
    for (int k = 0; k < 256; k++) begin
      logic ok;
      logic [7:0] p;
      ok = 1'b1;
      arc4_ks(k[23:0], n);
      for (int b = 0; b < n; b++) begin
        p = ct_mem[b + 1] ^ ks_arr[b];
        if (p < 8'h20 || p > 8'h7E) ok = 1'b0;
      end
      if (ok) return k[23:0];
    end
    return 24'hFFFFFF;
  endfunction

  task automatic load_mem(input int v);
    int n;
    n = vecs[v].len;
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    ct_mem[0] = n[7:0];
    arc4_ks(vecs[v].enc_key, n);
    for (int b = 0; b < n; b++)
      ct_mem[b + 1] = vecs[v].msg[8 * (n - 1 - b) +: 8] ^ ks_arr[b];
  endtask

  task automatic pulse_en();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!rdy && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    check("done_in_budget", {31'd0, rdy}, 32'd1);
  endtask

  task automatic run_vec(input int v);
    int cyc;
    load_mem(v);
    pulse_en();
    check("rdy_fall", {31'd0, rdy}, 32'd0);
    check("kv_cleared_on_en", {31'd0, key_valid}, 32'd0);
    wait_done(cyc);
    check("key", {8'd0, key}, {8'd0, vecs[v].exp_key});
    check("key_valid", {31'd0, key_valid}, {31'd0, vecs[v].exp_valid});
    if (vecs[v].len == 0) check("l0_latency_le_12", {31'd0, cyc <= 12}, 32'd1);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{enc_key: 24'h000018, len: 2, msg: 64'(  "Hi"), exp_key: 24'h0, exp_valid: 1'b1};
    vecs[1] = '{enc_key: 24'h000003, len: 2, msg: 64'(  "Hi"), exp_key: 24'h0, exp_valid: 1'b1};
    vecs[2] = '{enc_key: 24'h000000, len: 0, msg: 64'd0,       exp_key: 24'h0, exp_valid: 1'b1};
    vecs[3] = '{enc_key: 24'h000007, len: 3, msg: 64'( "Yes"), exp_key: 24'h0, exp_valid: 1'b1};
    vecs[4] = '{enc_key: 24'h000010, len: 4, msg: 64'("hey!"), exp_key: 24'h0, exp_valid: 1'b1};
    for (int v = 0; v < 5; v++) begin
      load_mem(v);
      vecs[v].exp_key = first_pass(vecs[v].len);
    end

    rst_n = 1'b1;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_kv", {31'd0, key_valid}, 32'd0);
    check("reset_key", {8'd0, key}, 32'd0);
    check("reset_ct_addr", {24'd0, ct_addr}, 32'd0);

    for (int v = 0; v < 5; v++) run_vec(v);

    // en held high while busy must not start a second search.
    load_mem(1);
    pulse_en();
    en = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_rdy_low", {31'd0, rdy}, 32'd0);
    en = 1'b0;
    wait_done(cyc);
    check("ignored_en_key", {8'd0, key}, {8'd0, vecs[1].exp_key});
    check("ignored_en_kv", {31'd0, key_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check("idle_after_ignored", {31'd0, rdy}, 32'd1);

    // Reset in the middle of a search, then a fresh run.
    load_mem(0);
    pulse_en();
    repeat (300) @(negedge clk);
    check("mid_search_busy", {31'd0, rdy}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_rdy", {31'd0, rdy}, 32'd1);
    check("abort_kv", {31'd0, key_valid}, 32'd0);
    check("abort_key", {8'd0, key}, 32'd0);
    check("abort_ct_addr", {24'd0, ct_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
